inst_fetch: RTL and testbench

Instruction fetch stage: owns the program counter, drives the address into the combinational instruction ROM, and latches the returned 32-bit word into an instruction register for the decode stage. Sits directly upstream of the instruction ROM and directly upstream of decode, with a valid/ready handshake toward decode. Accepts a single redirect port carrying the resolved branch/jump target from execute. Flags misaligned or out-of-window fetches and halts.

---
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction ROM and
// holds the fetched word in an instruction register offered to decode via valid/ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          ROM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstd,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Exclusive upper bound of the fetch window, widened so it cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(4 * ROM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic        advance;
    logic        pc_bad;

    assign advance = !ir_valid_q || id_ready;
    assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || ({1'b0, pc_q} >= WIN_END);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            RUN: begin
                if (redirect) begin
                    // A word handed over in this same cycle is consumed, then squashed.
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                end else if (pc_bad) begin
                    fetch_err_d = 1'b1;
                    state_d     = HALT;
                    if (id_ready) begin
                        ir_valid_d = 1'b0;
                    end
                end else if (advance) begin
                    ir_d       = rom_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (redirect || id_ready) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            ir_pc_q     <= 32'd0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign rom_addr  = pc_q[11:0];
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios against constants, then a randomized stream
// checked by an address-sequence scoreboard over a random-filled ROM.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rstd;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [31:0] pc;
    logic        fetch_err;

    logic [31:0] rom_mem [0:1023];
    int          n_cmp;
    int          n_bad;

    inst_fetch #(.RESET_PC(RESET_PC), .ROM_WORDS(1024)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    assign rom_data = rom_mem[rom_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RESET_PC;
        return rom_mem[off[11:2]];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_ir"}, ir, 32'd0);
        check({tag, "_ir_pc"}, ir_pc, 32'd0);
        check({tag, "_valid"}, {31'd0, ir_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        check({tag, "_rom_addr"}, {20'd0, rom_addr}, 32'h000);
    endtask

    // Leaves the bench just after an edge with rstd released; the next edge is IDLE->RUN.
    task automatic do_reset();
        rstd = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        id_ready = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rstd = 1'b1;
    endtask

    task automatic stream_scenario();
        do_reset();
        id_ready = 1'b1;
        step();
        check("edge1_valid", {31'd0, ir_valid}, 32'd0);
        check("edge1_pc", pc, RESET_PC);
        step();
        check("edge2_valid", {31'd0, ir_valid}, 32'd1);
        check("edge2_ir_pc", ir_pc, 32'h0040_0000);
        check("edge2_ir", ir, rom_mem[0]);
        check("edge2_pc", pc, 32'h0040_0004);
        check("edge2_rom_addr", {20'd0, rom_addr}, 32'h004);
        step();
        check("stream_ir_pc1", ir_pc, 32'h0040_0004);
        check("stream_ir1", ir, rom_mem[1]);
        step();
        check("stream_ir_pc2", ir_pc, 32'h0040_0008);
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_ir_pc", ir_pc, 32'h0040_0008);
            check("stall_ir", ir, rom_mem[2]);
            check("stall_pc", pc, 32'h0040_000C);
            check("stall_rom_addr", {20'd0, rom_addr}, 32'h00C);
            check("stall_valid", {31'd0, ir_valid}, 32'd1);
        end
        id_ready = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            step();
            check("stream_ir_pc", ir_pc, RESET_PC + 32'(4 * k));
            check("stream_ir", ir, rom_mem[k]);
            check("stream_rom_addr", {20'd0, rom_addr}, 32'(4 * k + 4));
        end
    endtask

    task automatic window_scenario(input bit hold_last);
        do_reset();
        id_ready = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0040_0FF0;
        step();
        check("win_redir_pc", pc, 32'h0040_0FF0);
        redirect = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        check("win_last_ir_pc", ir_pc, 32'h0040_0FFC);
        check("win_last_ir", ir, rom_mem[1023]);
        check("win_last_pc", pc, 32'h0040_1000);
        check("win_last_err", {31'd0, fetch_err}, 32'd0);
        if (hold_last) id_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("win_halt_err", {31'd0, fetch_err}, 32'd1);
            check("win_halt_pc", pc, 32'h0040_1000);
            check("win_halt_valid", {31'd0, ir_valid}, {31'd0, hold_last});
            check("win_halt_ir_pc", ir_pc, 32'h0040_0FFC);
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        int          consumed;
        bit          fire;
        bit          hold;

        n_cmp = 0;
        n_bad = 0;
        rstd = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        id_ready = 1'b0;
        for (int k = 0; k < 1024; k++) rom_mem[k] = $urandom;

        stream_scenario();

        // Redirect, then a misaligned redirect that halts the block.
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        step();
        check("redir_pre_ir_pc", ir_pc, 32'h0040_0004);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0040;
        step();
        check("redir_valid", {31'd0, ir_valid}, 32'd0);
        check("redir_pc", pc, 32'h0040_0040);
        redirect = 1'b0;
        step();
        check("redir_new_valid", {31'd0, ir_valid}, 32'd1);
        check("redir_new_ir_pc", ir_pc, 32'h0040_0040);
        check("redir_new_ir", ir, rom_mem[16]);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0042;
        step();
        check("mis_redir_pc", pc, 32'h0040_0042);
        check("mis_redir_err", {31'd0, fetch_err}, 32'd0);
        redirect = 1'b0;
        step();
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_valid", {31'd0, ir_valid}, 32'd0);
        check("mis_pc", pc, 32'h0040_0042);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0100;
        step();
        check("halt_ignore_redir_pc", pc, 32'h0040_0042);
        check("halt_ignore_redir_err", {31'd0, fetch_err}, 32'd1);
        redirect = 1'b0;

        window_scenario(1'b0);
        window_scenario(1'b1);

        // Asynchronous reset while a word is held and the block is halted.
        #3;
        rstd = 1'b0;
        #1;
        check_reset_values("async_reset");
        stream_scenario();

        // Randomized stream: every handed-over word must follow the fetch-address sequence.
        do_reset();
        exp_addr = RESET_PC;
        consumed = 0;
        for (int i = 0; i < 400; i++) begin
            id_ready = ($urandom_range(3) != 0);
            redirect = ($urandom_range(15) == 0);
            redirect_pc = RESET_PC + ($urandom_range(255) << 2);
            fire = ir_valid && id_ready;
            hold = ir_valid && !id_ready && !redirect;
            if (fire) begin
                check("rnd_take_ir_pc", ir_pc, exp_addr);
                check("rnd_take_ir", ir, word_at(exp_addr));
                exp_addr = exp_addr + 32'd4;
                consumed++;
            end
            step();
            check("rnd_err", {31'd0, fetch_err}, 32'd0);
            if (redirect) begin
                exp_addr = redirect_pc;
                check("rnd_redir_valid", {31'd0, ir_valid}, 32'd0);
                check("rnd_redir_pc", pc, redirect_pc);
            end else if (hold) begin
                check("rnd_hold_ir_pc", ir_pc, exp_addr);
                check("rnd_hold_ir", ir, word_at(exp_addr));
                check("rnd_hold_pc", pc, exp_addr + 32'd4);
            end
        end
        redirect = 1'b0;
        check("rnd_progress", {31'd0, consumed >= 60}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
